// File: rtl/button_gesture_pkg.sv
// Shared types and constants for the per-button gesture classifier.
// Imported by button_gesture_chan and button_gesture.
package button_gesture_pkg;

   localparam int CNT_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHORT = 2'd1,
      ST_LONG  = 2'd2
   } state_e;

endpackage

// File: rtl/button_gesture_chan.sv
// One button channel: IDLE/SHORT/LONG gesture FSM with a shared 32-bit counter.
// Auto-repeat is built only when BUTTON_GESTURE_REPEAT_EN is defined.
module button_gesture_chan
   import button_gesture_pkg::*;
#(
   parameter int unsigned LONG_DIV = 24000000,
   parameter int unsigned REP_DIV  = 6000000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic hold_i,
   input  logic press_i,
   input  logic release_i,
   output logic short_o,
   output logic long_o,
   output logic repeat_o,
   output logic active_o
);

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_DIV - 1);

   state_e           state;
   logic [CNT_W-1:0] cnt;
   logic             rel;

   // A dropped hold level counts as a release even without the pulse.
   assign rel      = release_i | ~hold_i;
   assign active_o = (state != ST_IDLE);

`ifdef BUTTON_GESTURE_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REP_DIV - 1);
   logic rep_q;
   assign repeat_o = rep_q;
`else
   localparam int unsigned UNUSED_REP_DIV = REP_DIV;
   assign repeat_o = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         short_o <= 1'b0;
         long_o  <= 1'b0;
`ifdef BUTTON_GESTURE_REPEAT_EN
         rep_q   <= 1'b0;
`endif
      end else begin
         short_o <= 1'b0;
         long_o  <= 1'b0;
`ifdef BUTTON_GESTURE_REPEAT_EN
         rep_q   <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (press_i) begin
                  state <= ST_SHORT;
                  cnt   <= '0;
               end
            end
            ST_SHORT: begin
               // Release outranks the threshold when both land in one cycle.
               if (rel) begin
                  short_o <= 1'b1;
                  state   <= ST_IDLE;
               end else if (cnt == LONG_LAST) begin
                  long_o <= 1'b1;
                  state  <= ST_LONG;
                  cnt    <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_LONG: begin
               if (rel) begin
                  state <= ST_IDLE;
`ifdef BUTTON_GESTURE_REPEAT_EN
               end else if (cnt == REP_LAST) begin
                  rep_q <= 1'b1;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
`endif
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/button_gesture.sv
// Gesture classifier top: NUM independent button_gesture_chan instances.
// Optional auto-repeat is selected with BUTTON_GESTURE_REPEAT_EN.
module button_gesture
   import button_gesture_pkg::*;
#(
   parameter int unsigned NUM      = 4,
   parameter int unsigned LONG_DIV = 24000000,
   parameter int unsigned REP_DIV  = 6000000
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic [NUM-1:0] button_hold_i,
   input  logic [NUM-1:0] button_press_i,
   input  logic [NUM-1:0] button_release_i,
   output logic [NUM-1:0] button_short_o,
   output logic [NUM-1:0] button_long_o,
   output logic [NUM-1:0] button_repeat_o,
   output logic [NUM-1:0] button_active_o
);

   for (genvar i = 0; i < NUM; i++) begin : g_chan
      button_gesture_chan #(
         .LONG_DIV (LONG_DIV),
         .REP_DIV  (REP_DIV)
      ) u_chan (
         .clk_i     (clk_i),
         .rst_i     (rst_i),
         .hold_i    (button_hold_i[i]),
         .press_i   (button_press_i[i]),
         .release_i (button_release_i[i]),
         .short_o   (button_short_o[i]),
         .long_o    (button_long_o[i]),
         .repeat_o  (button_repeat_o[i]),
         .active_o  (button_active_o[i])
      );
   end

endmodule
